// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of one memory controller.
// Grants one master at a time, registers its command, routes completion back.
module mem_arbiter #(
    parameter bit          RR      = 1'b1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        mclk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_rw_req,
    input  logic        m0_rw,
    input  logic [31:0] m0_write_data,
    input  logic [1:0]  m0_size,
    output logic [31:0] m0_read_data,
    output logic        m0_data_valid,
    output logic        m0_err,

    input  logic [31:0] m1_address,
    input  logic        m1_rw_req,
    input  logic        m1_rw,
    input  logic [31:0] m1_write_data,
    input  logic [1:0]  m1_size,
    output logic [31:0] m1_read_data,
    output logic        m1_data_valid,
    output logic        m1_err,

    output logic [31:0] mem_address,
    output logic        mem_rw_req,
    output logic        mem_rw,
    output logic [31:0] mem_write_data,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_read_data,
    input  logic        mem_data_valid
);

    // A zero TIMEOUT still needs a legal 1-bit counter.
    localparam int unsigned WDW =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_grant;
    logic            r_last;
    logic [WDW-1:0]  r_wdog;

    logic [31:0]     r_mem_address;
    logic            r_mem_rw_req;
    logic            r_mem_rw;
    logic [31:0]     r_mem_write_data;
    logic [1:0]      r_mem_size;

    logic [1:0][31:0] r_rd;
    logic [1:0]      r_dv;
    logic [1:0]      r_err;

    logic            w_pick;
    logic            w_any_req;
    logic            w_gnt_req;
    logic            w_timeout;
    logic [31:0]     w_cmd_address;
    logic            w_cmd_rw;
    logic [31:0]     w_cmd_write_data;
    logic [1:0]      w_cmd_size;

    logic            w_start;
    logic            w_ack;
    logic            w_complete;
    logic            w_expire;
    logic            w_release;
    logic            w_busy;

    // Arbitration: who would win, and the command that master presents.
    always_comb begin
        w_pick    = 1'b0;
        w_any_req = m0_rw_req | m1_rw_req;
        unique case ({m1_rw_req, m0_rw_req})
            2'b10:   w_pick = 1'b1;
            2'b11:   w_pick = RR ? ~r_last : 1'b0;
            default: w_pick = 1'b0;
        endcase
        w_cmd_address    = w_pick ? m1_address    : m0_address;
        w_cmd_rw         = w_pick ? m1_rw         : m0_rw;
        w_cmd_write_data = w_pick ? m1_write_data : m0_write_data;
        w_cmd_size       = w_pick ? m1_size       : m0_size;
        w_gnt_req        = r_grant ? m1_rw_req : m0_rw_req;
        w_timeout        = (TIMEOUT != 0) && (r_wdog == WDOG_LAST);
    end

    // State register.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a held controller completion blocks arbitration.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (!mem_data_valid && w_any_req) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_data_valid) begin
                    w_next = w_gnt_req ? S_DONE : S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!w_gnt_req) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: one-cycle action strobes for the datapath registers.
    always_comb begin
        w_busy     = (r_state == S_BUSY);
        w_start    = (r_state == S_IDLE) && (w_next == S_BUSY);
        w_ack      = w_busy && mem_data_valid;
        w_complete = w_ack && w_gnt_req;
        w_expire   = w_busy && !mem_data_valid && w_timeout;
        w_release  = (r_state == S_DONE) && !w_gnt_req;
    end

    // Controller command: latched on grant, frozen through the access.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_mem_address    <= '0;
            r_mem_rw_req     <= 1'b0;
            r_mem_rw         <= 1'b0;
            r_mem_write_data <= '0;
            r_mem_size       <= '0;
        end else if (w_start) begin
            r_mem_address    <= w_cmd_address;
            r_mem_rw_req     <= 1'b1;
            r_mem_rw         <= w_cmd_rw;
            r_mem_write_data <= w_cmd_write_data;
            r_mem_size       <= w_cmd_size;
        end else if (w_ack || w_expire) begin
            r_mem_rw_req     <= 1'b0;
        end
    end

    // Grant bookkeeping and watchdog; last starts at 1 so master 0 wins first.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_wdog  <= '0;
        end else if (w_start) begin
            r_grant <= w_pick;
            r_last  <= w_pick;
            r_wdog  <= '0;
        end else if (w_busy) begin
            r_wdog  <= r_wdog + 1'b1;
        end
    end

    // Completion path: only the granted master's slot is ever touched.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_rd  <= '0;
            r_dv  <= '0;
            r_err <= '0;
        end else begin
            if (w_ack) begin
                r_rd[r_grant] <= mem_read_data;
            end else if (w_expire) begin
                r_rd[r_grant] <= '0;
            end
            if (w_complete || w_expire) begin
                r_dv[r_grant]  <= 1'b1;
                r_err[r_grant] <= w_expire;
            end else if (w_release) begin
                r_dv[r_grant]  <= 1'b0;
                r_err[r_grant] <= 1'b0;
            end
        end
    end

    assign mem_address    = r_mem_address;
    assign mem_rw_req     = r_mem_rw_req;
    assign mem_rw         = r_mem_rw;
    assign mem_write_data = r_mem_write_data;
    assign mem_size       = r_mem_size;

    assign m0_read_data   = r_rd[0];
    assign m0_data_valid  = r_dv[0];
    assign m0_err         = r_err[0];
    assign m1_read_data   = r_rd[1];
    assign m1_data_valid  = r_dv[1];
    assign m1_err         = r_err[1];

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random traffic on two arbiters
// (round-robin and fixed priority) against a transaction-level model.
module tb_mem_arbiter;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_addr [2][2];
    logic        a_req  [2][2];
    logic        a_rw   [2][2];
    logic [31:0] a_wd   [2][2];
    logic [1:0]  a_sz   [2][2];
    logic [31:0] o_rd   [2][2];
    logic        o_dv   [2][2];
    logic        o_err  [2][2];
    logic [31:0] c_addr [2];
    logic        c_req  [2];
    logic        c_rw   [2];
    logic [31:0] c_wd   [2];
    logic [1:0]  c_sz   [2];
    logic [31:0] c_rd   [2];
    logic        c_dv   [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        mem_arbiter #(.RR(d == 0), .TIMEOUT(TO)) u_dut (
            .mclk           (clk),
            .reset          (rst),
            .m0_address     (a_addr[d][0]),
            .m0_rw_req      (a_req[d][0]),
            .m0_rw          (a_rw[d][0]),
            .m0_write_data  (a_wd[d][0]),
            .m0_size        (a_sz[d][0]),
            .m0_read_data   (o_rd[d][0]),
            .m0_data_valid  (o_dv[d][0]),
            .m0_err         (o_err[d][0]),
            .m1_address     (a_addr[d][1]),
            .m1_rw_req      (a_req[d][1]),
            .m1_rw          (a_rw[d][1]),
            .m1_write_data  (a_wd[d][1]),
            .m1_size        (a_sz[d][1]),
            .m1_read_data   (o_rd[d][1]),
            .m1_data_valid  (o_dv[d][1]),
            .m1_err         (o_err[d][1]),
            .mem_address    (c_addr[d]),
            .mem_rw_req     (c_req[d]),
            .mem_rw         (c_rw[d]),
            .mem_write_data (c_wd[d]),
            .mem_size       (c_sz[d]),
            .mem_read_data  (c_rd[d]),
            .mem_data_valid (c_dv[d])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    // model: 0 = idle, 1 = access outstanding, 2 = completion held
    int          ph    [2];
    int          g     [2];
    int          last  [2];
    int          wd    [2];
    logic [31:0] e_addr[2];
    logic [31:0] e_wd  [2];
    logic        e_rw  [2];
    logic [1:0]  e_sz  [2];
    logic        e_err [2];
    logic [31:0] e_rd  [2][2];

    bit   mute  [2];
    bit   rnd_lat;
    int   lat   [2];
    int   cnt   [2];
    bit   autoq [2][2];
    int   rate;
    logic prev_req [2];
    int   gseq  [2][$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdf(input logic [31:0] a);
        return (a == 32'h8C) ? 32'h0000_0513 : (a ^ 32'hC3A5_5A3C);
    endfunction

    task automatic raise(input int d, input int n, input logic [31:0] ad,
                         input logic rw, input logic [31:0] wdat,
                         input logic [1:0] sz);
        a_addr[d][n] = ad;
        a_rw[d][n]   = rw;
        a_wd[d][n]   = wdat;
        a_sz[d][n]   = sz;
        a_req[d][n]  = 1'b1;
    endtask

    // Apply the arbitration rules to what was sampled at this edge.
    task automatic model(input int d);
        int    w;
        string p;
        p = $sformatf("d%0d", d);
        if (rst) begin
            ph[d]      = 0;
            last[d]    = 1;
            wd[d]      = 0;
            e_err[d]   = 1'b0;
            e_rd[d][0] = '0;
            e_rd[d][1] = '0;
            chk({p, " rst addr"}, c_addr[d], 32'h0);
            chk({p, " rst wdata"}, c_wd[d], 32'h0);
            chk({p, " rst rw"}, 32'(c_rw[d]), 32'h0);
            chk({p, " rst size"}, 32'(c_sz[d]), 32'h0);
        end else begin
            case (ph[d])
                0: if (!c_dv[d] && (a_req[d][0] || a_req[d][1])) begin
                    if (a_req[d][0] && a_req[d][1])
                        w = (d == 0) ? 1 - last[d] : 0;
                    else
                        w = a_req[d][1] ? 1 : 0;
                    g[d]      = w;
                    last[d]   = w;
                    wd[d]     = 0;
                    ph[d]     = 1;
                    e_addr[d] = a_addr[d][w];
                    e_wd[d]   = a_wd[d][w];
                    e_rw[d]   = a_rw[d][w];
                    e_sz[d]   = a_sz[d][w];
                end
                1: begin
                    if (c_dv[d]) begin
                        e_rd[d][g[d]] = c_rd[d];
                        e_err[d]      = 1'b0;
                        ph[d]         = a_req[d][g[d]] ? 2 : 0;
                    end else if (wd[d] == TO - 1) begin
                        e_rd[d][g[d]] = '0;
                        e_err[d]      = 1'b1;
                        ph[d]         = 2;
                    end else begin
                        wd[d]++;
                    end
                end
                default: if (!a_req[d][g[d]]) ph[d] = 0;
            endcase
        end
        chk({p, " mem_rw_req"}, 32'(c_req[d]), 32'(ph[d] == 1));
        if (ph[d] == 1) begin
            chk({p, " mem_address"}, c_addr[d], e_addr[d]);
            chk({p, " mem_write_data"}, c_wd[d], e_wd[d]);
            chk({p, " mem_rw"}, 32'(c_rw[d]), 32'(e_rw[d]));
            chk({p, " mem_size"}, 32'(c_sz[d]), 32'(e_sz[d]));
        end
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("%s m%0d data_valid", p, n), 32'(o_dv[d][n]),
                32'(ph[d] == 2 && g[d] == n));
            chk($sformatf("%s m%0d err", p, n), 32'(o_err[d][n]),
                32'(ph[d] == 2 && g[d] == n && e_err[d]));
            chk($sformatf("%s m%0d read_data", p, n), o_rd[d][n],
                e_rd[d][n]);
        end
    endtask

    // One clock: check outputs, then act as controller and masters.
    task automatic step();
        logic [31:0] ra;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) model(d);
        for (int d = 0; d < 2; d++) begin
            if (c_req[d] && !prev_req[d])
                gseq[d].push_back((c_addr[d] == a_addr[d][1]) ? 1 : 0);
            prev_req[d] = c_req[d];
            if (!c_req[d]) begin
                c_dv[d] = 1'b0;
                cnt[d]  = 0;
                if (rnd_lat) lat[d] = int'($urandom_range(0, 4));
            end else if (!c_dv[d] && !mute[d]) begin
                if (cnt[d] >= lat[d]) begin
                    c_dv[d] = 1'b1;
                    c_rd[d] = rdf(c_addr[d]);
                end else begin
                    cnt[d]++;
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (a_req[d][n] && o_dv[d][n]) begin
                    a_req[d][n] = 1'b0;
                end else if (!a_req[d][n] && !o_dv[d][n] && autoq[d][n] &&
                             int'($urandom_range(0, 99)) < rate) begin
                    ra = $urandom;
                    ra[30:29] = (n == 1) ? 2'b10 : 2'b01;
                    raise(d, n, ra, 1'($urandom_range(0, 1)), $urandom,
                          2'($urandom_range(0, 2)));
                end
            end
        end
    endtask

    task automatic wait_dv(input int d, input int n, input string tag);
        for (int i = 0; i < 40 && !o_dv[d][n]; i++) step();
        chk(tag, 32'(o_dv[d][n]), 32'd1);
    endtask

    initial begin
        int   cyc;
        int   k1;
        logic seen;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
                a_addr[d][n] = '0;
                a_req[d][n]  = 1'b0;
                a_rw[d][n]   = 1'b0;
                a_wd[d][n]   = '0;
                a_sz[d][n]   = '0;
                autoq[d][n]  = 1'b0;
                e_rd[d][n]   = '0;
            end
            c_dv[d] = 1'b0;
            c_rd[d] = '0;
            mute[d] = 1'b0;
            lat[d]  = 0;
            cnt[d]  = 0;
            ph[d]   = 0;
            g[d]    = 0;
            last[d] = 1;
            wd[d]   = 0;
            e_err[d] = 1'b0;
            prev_req[d] = 1'b0;
        end
        rnd_lat = 1'b0;
        rate    = 100;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // single read
        lat[0] = 2;
        raise(0, 0, 32'h8C, 1'b0, 32'h0, 2'd2);
        step();
        chk("rd cmd req", 32'(c_req[0]), 32'd1);
        chk("rd cmd addr", c_addr[0], 32'h8C);
        chk("rd cmd rw", 32'(c_rw[0]), 32'd0);
        chk("rd cmd size", 32'(c_sz[0]), 32'd2);
        wait_dv(0, 0, "rd dv");
        chk("rd data", o_rd[0][0], 32'h0000_0513);
        chk("rd m1 dv", 32'(o_dv[0][1]), 32'd0);
        repeat (4) step();

        // continuous ties: RR alternates, fixed priority starves m1
        rst = 1'b1;
        step();
        rst = 1'b0;
        lat[0] = 1;
        lat[1] = 1;
        gseq[0].delete();
        gseq[1].delete();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 2; n++) autoq[d][n] = 1'b1;
        repeat (60) step();
        autoq[0][0] = 1'b0;
        autoq[0][1] = 1'b0;
        autoq[1][0] = 1'b0;
        k1 = gseq[1].size();
        chk("rr grants", 32'(gseq[0].size() >= 8), 32'd1);
        chk("fp grants", 32'(k1 >= 8), 32'd1);
        for (int i = 0; i < 8 && i < gseq[0].size(); i++)
            chk($sformatf("rr grant %0d", i), 32'(gseq[0][i]), 32'(i % 2));
        for (int i = 0; i < k1; i++)
            chk($sformatf("fp grant %0d", i), 32'(gseq[1][i]), 32'd0);
        repeat (30) step();
        autoq[1][1] = 1'b0;
        repeat (20) step();
        chk("fp m1 served", 32'(gseq[1].size() > k1), 32'd1);
        if (gseq[1].size() > k1)
            chk("fp m1 last", 32'(gseq[1][gseq[1].size() - 1]), 32'd1);

        // write passthrough, master inputs change during BUSY
        lat[0] = 4;
        raise(0, 1, 32'h0000_1FF8, 1'b1, 32'hDEAD_BEEF, 2'd0);
        step();
        chk("wr cmd addr", c_addr[0], 32'h0000_1FF8);
        a_wd[0][1]   = 32'h0;
        a_addr[0][1] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("wr hold wdata", c_wd[0], 32'hDEAD_BEEF);
            chk("wr hold size", 32'(c_sz[0]), 32'd0);
            chk("wr hold rw", 32'(c_rw[0]), 32'd1);
        end
        wait_dv(0, 1, "wr dv");
        chk("wr m0 dv", 32'(o_dv[0][0]), 32'd0);
        repeat (4) step();

        // watchdog
        mute[0] = 1'b1;
        raise(0, 0, 32'h0000_4000, 1'b0, 32'h0, 2'd2);
        step();
        chk("to req", 32'(c_req[0]), 32'd1);
        cyc = 0;
        for (int i = 0; i < 40 && !o_dv[0][0]; i++) begin
            step();
            cyc++;
        end
        chk("to cycles", 32'(cyc), 32'd8);
        chk("to dv", 32'(o_dv[0][0]), 32'd1);
        chk("to err", 32'(o_err[0][0]), 32'd1);
        chk("to data", o_rd[0][0], 32'h0);
        chk("to req low", 32'(c_req[0]), 32'd0);
        repeat (3) step();

        // abandoned access
        mute[0] = 1'b0;
        lat[0]  = 5;
        raise(0, 0, 32'h0000_4004, 1'b0, 32'h0, 2'd2);
        step();
        step();
        step();
        a_req[0][0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_dv[0][0] !== 1'b0) seen = 1'b1;
        end
        chk("abandon dv", 32'(seen), 32'd0);
        chk("abandon req low", 32'(c_req[0]), 32'd0);
        raise(0, 1, 32'h0000_4008, 1'b0, 32'h0, 2'd2);
        step();
        chk("abandon regrant", 32'(c_req[0]), 32'd1);
        chk("abandon regrant addr", c_addr[0], 32'h0000_4008);
        wait_dv(0, 1, "abandon next dv");
        repeat (3) step();

        // reset mid-access
        lat[0] = 6;
        raise(0, 0, 32'h0000_0100, 1'b0, 32'h0, 2'd2);
        step();
        step();
        chk("mid rst busy", 32'(c_req[0]), 32'd1);
        rst = 1'b1;
        a_req[0][0] = 1'b0;
        step();
        chk("mid rst req", 32'(c_req[0]), 32'd0);
        chk("mid rst m0 data", o_rd[0][0], 32'h0);
        chk("mid rst m1 data", o_rd[0][1], 32'h0);
        rst = 1'b0;
        raise(0, 0, 32'h0000_0104, 1'b0, 32'h0, 2'd2);
        step();
        chk("post rst grant", 32'(c_req[0]), 32'd1);
        chk("post rst addr", c_addr[0], 32'h0000_0104);
        wait_dv(0, 0, "post rst dv");
        repeat (3) step();

        // random traffic on both arbiters
        rnd_lat = 1'b1;
        rate    = 25;
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 2; n++) autoq[d][n] = 1'b1;
        repeat (800) step();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 2; n++) autoq[d][n] = 1'b0;
        repeat (40) step();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
